// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, flag register, timeout and illegal-opcode error trap.
// Zero-wait latency 3 (branch/call/jr), 4 (ALU/li/move/store), 5 (load); FETCH and MEM hold their strobes until ack.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [3:0]  FLAG_RST    = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       fetch_ack,
  input  logic       mem_ack,
  input  logic [3:0] alu_flags,
  output logic       fetch_req,
  output logic       ir_ld,
  output logic       rdr1,
  output logic       rdr2,
  output logic [1:0] x_sel,
  output logic [1:0] off_sel,
  output logic [2:0] fsel,
  output logic       alu_ld,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       rz_ld,
  output logic       rm_ld,
  output logic       rpc_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic [3:0] flags,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [4:0] ir_op;
  logic [7:0] wcnt;
  logic [1:0] err_set;
  logic       wait_last;

  logic is_br, is_call, is_jr, is_ill, is_mem, is_alu, alu_reg;
  logic is_li, is_mv, is_ld, is_st;
  logic br_taken;

  assign is_br   = ir_op[4] && (ir_op[3:0] <= 4'd8);
  assign is_call = (ir_op == 5'b11001);
  assign is_jr   = (ir_op == 5'b11010);
  assign is_ill  = ir_op[4] && (ir_op[3:0] >= 4'd11);
  assign is_mem  = !ir_op[4] && (ir_op[3:2] == 2'b11);
  assign is_alu  = !ir_op[4] && !is_mem;
  assign alu_reg = (ir_op[3:1] == 3'b100) || ir_op[0];
  assign is_li   = is_mem && (ir_op[1:0] == 2'b00);
  assign is_mv   = is_mem && (ir_op[1:0] == 2'b01);
  assign is_ld   = is_mem && (ir_op[1:0] == 2'b10);
  assign is_st   = is_mem && (ir_op[1:0] == 2'b11);

  assign wait_last = (wcnt == WAIT_LAST);
  assign busy      = (state != FETCH);
  assign err       = (state == ERR);

  // Branch conditions test the registered flags {C,V,S,Z}, never the live ALU output.
  always_comb begin
    br_taken = 1'b0;
    case (ir_op[3:0])
      4'd0:    br_taken = 1'b1;
      4'd1:    br_taken = flags[0];
      4'd2:    br_taken = !flags[0];
      4'd3:    br_taken = flags[3];
      4'd4:    br_taken = !flags[3];
      4'd5:    br_taken = flags[2];
      4'd6:    br_taken = !flags[2];
      4'd7:    br_taken = flags[1];
      4'd8:    br_taken = !flags[1];
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      ir_op    <= '0;
      flags    <= FLAG_RST;
      err_code <= '0;
      wcnt     <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && fetch_ack) ir_op <= opcode;
      if (state == EXEC && is_alu) flags <= alu_flags;
      if (err_set != 2'b00) err_code <= err_set;
      // Any state change clears the wait counter, so it starts at 0 on entry to FETCH/MEM.
      if (state_nxt != state) wcnt <= '0;
      else if (state == FETCH || state == MEM) wcnt <= wcnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 2'b00;
    fetch_req = 1'b0;
    ir_ld     = 1'b0;
    rdr1      = 1'b0;
    rdr2      = 1'b0;
    x_sel     = 2'd0;
    off_sel   = 2'd0;
    fsel      = 3'd0;
    alu_ld    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    rz_ld     = 1'b0;
    rm_ld     = 1'b0;
    rpc_ld    = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    case (state)
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) begin
          ir_ld     = 1'b1;
          state_nxt = DECODE;
        end else if (wait_last) begin
          state_nxt = ERR;
          err_set   = 2'b01;
        end
      end
      DECODE: begin
        if (is_ill) begin
          state_nxt = ERR;
          err_set   = 2'b10;
        end else begin
          rdr1      = is_jr || is_st || is_alu;
          rdr2      = is_mv || is_ld || is_st || (is_alu && alu_reg);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_ld = 1'b1;
        if (is_br) begin
          x_sel     = 2'd3;
          off_sel   = 2'd3;
          pc_ld     = br_taken;
          pc_inc    = !br_taken;
          state_nxt = FETCH;
        end else if (is_call) begin
          x_sel     = 2'd3;
          off_sel   = 2'd2;
          rpc_ld    = 1'b1;
          pc_ld     = 1'b1;
          state_nxt = FETCH;
        end else if (is_jr) begin
          x_sel     = 2'd1;
          fsel      = 3'd6;
          pc_ld     = 1'b1;
          state_nxt = FETCH;
        end else if (is_li) begin
          off_sel   = 2'd2;
          fsel      = 3'd7;
          state_nxt = WB;
        end else if (is_mv) begin
          x_sel     = 2'd2;
          fsel      = 3'd6;
          state_nxt = WB;
        end else if (is_ld || is_st) begin
          x_sel     = 2'd2;
          off_sel   = 2'd1;
          state_nxt = MEM;
        end else begin
          x_sel     = 2'd1;
          off_sel   = alu_reg ? 2'd0 : 2'd2;
          fsel      = ir_op[3:1];
          state_nxt = WB;
        end
      end
      MEM: begin
        mem_rd = is_ld;
        mem_wr = is_st;
        if (mem_ack) begin
          if (is_ld) begin
            state_nxt = WB;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = FETCH;
          end
        end else if (wait_last) begin
          state_nxt = ERR;
          err_set   = 2'b01;
        end
      end
      WB: begin
        rz_ld     = !is_ld;
        rm_ld     = is_ld;
        pc_inc    = 1'b1;
        state_nxt = FETCH;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with MEM_TIMEOUT=4; inputs driven on the falling edge,
// outputs sampled 1ns later, expected values hand-computed per instruction cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] opcode = '0;
  logic       fetch_ack = 1'b0;
  logic       mem_ack = 1'b0;
  logic [3:0] alu_flags = '0;
  logic       fetch_req, ir_ld, rdr1, rdr2;
  logic [1:0] x_sel, off_sel;
  logic [2:0] fsel;
  logic       alu_ld, mem_rd, mem_wr, rz_ld, rm_ld, rpc_ld, pc_inc, pc_ld;
  logic [3:0] flags;
  logic       busy, err;
  logic [1:0] err_code;
  logic [18:0] strb;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_controller #(.MEM_TIMEOUT(4), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .fetch_ack(fetch_ack), .mem_ack(mem_ack),
    .alu_flags(alu_flags), .fetch_req(fetch_req), .ir_ld(ir_ld), .rdr1(rdr1), .rdr2(rdr2),
    .x_sel(x_sel), .off_sel(off_sel), .fsel(fsel), .alu_ld(alu_ld), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .rz_ld(rz_ld), .rm_ld(rm_ld), .rpc_ld(rpc_ld), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .flags(flags), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // fetch_req is bit 18, pc_ld is bit 0
  assign strb = {fetch_req, ir_ld, rdr1, rdr2, x_sel, off_sel, fsel, alu_ld,
                 mem_rd, mem_wr, rz_ld, rm_ld, rpc_ld, pc_inc, pc_ld};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, 32'(dut.state), 32'(exp));
  endtask

  task automatic cyc(input logic r, input logic [4:0] op, input logic fa, input logic ma,
                     input logic [3:0] af);
    @(negedge clk);
    rst = r; opcode = op; fetch_ack = fa; mem_ack = ma; alu_flags = af;
    #1;
  endtask

  initial begin
    // reset
    cyc(1'b1, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk_st("rst_state", 3'd0);
    chk("rst_strb", 32'(strb), 32'h40000);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_err", 32'({err, err_code}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // ALU register form 0_0011
    cyc(1'b0, 5'b00011, 1'b1, 1'b0, 4'h0);
    chk_st("alu_f_state", 3'd0);
    chk("alu_f_irld", 32'({fetch_req, ir_ld}), 32'h3);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk_st("alu_d_state", 3'd1);
    chk("alu_d_rdr", 32'({rdr1, rdr2, alu_ld}), 32'h6);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'b0001);
    chk_st("alu_e_state", 3'd2);
    chk("alu_e_ctl", 32'({alu_ld, x_sel, off_sel, fsel}), 32'({1'b1, 2'd1, 2'd0, 3'd1}));
    chk("alu_e_flags_old", 32'(flags), 32'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk_st("alu_w_state", 3'd4);
    chk("alu_w_ld", 32'({rz_ld, rm_ld, pc_inc}), 32'b101);
    chk("alu_w_flags", 32'(flags), 32'b0001);

    // branch on Z=1: taken, alu_flags ignored
    cyc(1'b0, 5'b10001, 1'b1, 1'b0, 4'h0);
    chk_st("bz_f_state", 3'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("bz_d_rdr", 32'({rdr1, rdr2}), 32'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'hF);
    chk_st("bz_e_state", 3'd2);
    chk("bz_e_pc", 32'({pc_ld, pc_inc, x_sel, off_sel}), 32'({1'b1, 1'b0, 2'd3, 2'd3}));

    // ALU immediate form 0_0100 sets flags C=1, Z=0
    cyc(1'b0, 5'b00100, 1'b1, 1'b0, 4'h0);
    chk_st("bz_lat3", 3'd0);
    chk("bz_flags_kept", 32'(flags), 32'b0001);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ali_d_rdr", 32'({rdr1, rdr2}), 32'b10);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'b1000);
    chk("ali_e_ctl", 32'({x_sel, off_sel, fsel}), 32'({2'd1, 2'd2, 3'd2}));
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ali_w_flags", 32'(flags), 32'b1000);

    // branch on Z with Z=0: not taken
    cyc(1'b0, 5'b10001, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("bnz_e_pc", 32'({pc_ld, pc_inc}), 32'b01);

    // branch on C with C=1: taken
    cyc(1'b0, 5'b10011, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("bc_e_pc", 32'({pc_ld, pc_inc}), 32'b10);

    // call
    cyc(1'b0, 5'b11001, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("call_e_ctl", 32'({x_sel, off_sel, rpc_ld, pc_ld}), 32'({2'd3, 2'd2, 1'b1, 1'b1}));

    // load with 3 wait cycles, ack on 4th MEM cycle (timeout boundary)
    cyc(1'b0, 5'b01110, 1'b1, 1'b0, 4'h0);
    chk_st("call_lat3", 3'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ld_d_rdr", 32'({rdr1, rdr2}), 32'b01);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ld_e_ctl", 32'({x_sel, off_sel, fsel}), 32'({2'd2, 2'd1, 3'd0}));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
      chk("ld_m_wait", 32'({dut.state, mem_rd, pc_inc}), 32'({3'd3, 1'b1, 1'b0}));
    end
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 4'h0);
    chk("ld_m_ack", 32'({dut.state, mem_rd, pc_inc}), 32'({3'd3, 1'b1, 1'b0}));
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk_st("ld_w_state", 3'd4);
    chk("ld_w_ld", 32'({rz_ld, rm_ld, pc_inc}), 32'b011);

    // store zero-wait
    cyc(1'b0, 5'b01111, 1'b1, 1'b0, 4'h0);
    chk_st("ld_done", 3'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("st_d_rdr", 32'({rdr1, rdr2}), 32'b11);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 4'h0);
    chk("st_m_ack", 32'({dut.state, mem_wr, pc_inc}), 32'({3'd3, 1'b1, 1'b1}));

    // illegal opcode
    cyc(1'b0, 5'b11100, 1'b1, 1'b0, 4'h0);
    chk_st("st_lat4", 3'd0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ill_d", 32'({dut.state, alu_ld}), 32'({3'd1, 1'b0}));
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ill_err", 32'({dut.state, err, err_code, busy}), 32'({3'd7, 1'b1, 2'b10, 1'b1}));
    chk("ill_strb", 32'(strb), 32'h0);
    cyc(1'b1, 5'd0, 1'b1, 1'b1, 4'h0);
    chk_st("ill_hold", 3'd7);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ill_rst_strb", 32'(strb), 32'h40000);
    chk("ill_rst_err", 32'({dut.state, err, err_code, flags}), 32'h0);

    // store timeout: mem_ack never arrives
    cyc(1'b0, 5'b01111, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
      chk("to_m_wait", 32'({dut.state, mem_wr, pc_inc}), 32'({3'd3, 1'b1, 1'b0}));
    end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("to_err", 32'({dut.state, err, err_code}), 32'({3'd7, 1'b1, 2'b01}));
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 5'd0, 1'b1, 1'b1, 4'h0);
      chk("to_hold", 32'({dut.state, strb}), 32'({3'd7, 19'h0}));
    end
    cyc(1'b1, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("to_rst", 32'({dut.state, strb, err_code}), 32'({3'd0, 19'h40000, 2'b00}));

    // set flags, then reset in the middle of a load wait
    cyc(1'b0, 5'b00011, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'b0110);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("mr_flags_set", 32'(flags), 32'b0110);
    cyc(1'b0, 5'b01110, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("mr_in_mem", 32'({dut.state, mem_rd}), 32'({3'd3, 1'b1}));
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("mr_after", 32'({dut.state, mem_rd, fetch_req, flags}), 32'({3'd0, 1'b0, 1'b1, 4'h0}));

    // fetch timeout: the previous cycle was FETCH wait 1
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
      chk("ft_wait", 32'({dut.state, fetch_req}), 32'({3'd0, 1'b1}));
    end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    chk("ft_err", 32'({dut.state, err, err_code, strb}), 32'({3'd7, 1'b1, 2'b01, 19'h0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
